// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/busy/done handshake and operand/result bundle for the divider
interface seq_restoring_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative restoring divider, one quotient bit per clock
// DIV_SIGNED_EN selects two's complement operands (sign-magnitude around the unsigned core).
module seq_restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif

    // R < D always holds, so the shifted value minus D fits WIDTH+1 bits with a valid sign bit.
    r_shift = {r_q, q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, d_q};
    q_next  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    r_next  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef DIV_SIGNED_EN
          q_d    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          d_d    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
          qneg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rneg_d = bus.dividend[WIDTH-1];
`else
          q_d    = bus.dividend;
          d_d    = bus.divisor;
`endif
          r_d     = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = (bus.divisor == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        q_d     = q_next;
        r_d     = r_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
          quotient_d  = qneg_q ? -q_next : q_next;
          remainder_d = rneg_q ? -r_next : r_next;
`else
          quotient_d  = q_next;
          remainder_d = r_next;
`endif
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FIN: begin
        // Only reached on a zero divisor: Q still holds the (magnitude of the) dividend.
        quotient_d  = '1;
`ifdef DIV_SIGNED_EN
        remainder_d = rneg_q ? -q_q : q_q;
`else
        remainder_d = q_q;
`endif
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule
